vec_relu_grad: RTL
==================

# vec_relu_grad

Backward-pass companion to the forward vector ReLU. It accepts one forward-activation vector and the matching upstream-gradient vector through a valid/ready handshake. It then walks the vector `LANES` elements per cycle, passing each gradient element where its activation was strictly positive and writing +0 elsewhere. The resulting gradient vector and pass mask are presented through a valid/ready output handshake. It sits between the loss/gradient datapath and the weight-update stage.

## Interface
- `EXP_WIDTH`, 8: float exponent bits.
- `FRAC_WIDTH`, 23: float fraction bits.
  - Element width W = 1 + EXP_WIDTH + FRAC_WIDTH.
- `VEC_SIZE`, 4: elements per vector.
- `LANES`, 1: elements processed per cycle.
  - VEC_SIZE % LANES == 0 is required.
  - BEATS = VEC_SIZE / LANES.
- `clk`  in  1: clock. One clock domain only.
- `reset`  in  1: reset, synchronous, active-high.
- `in_valid`  in  1: `act_in` and `grad_in` are valid.
- `in_ready`  out  1: block can accept a vector.
- `act_in`  in  VEC_SIZE*W: forward activations, element i at bits [i*W +: W].
- `grad_in`  in  VEC_SIZE*W: upstream gradients, same packing.
- `out_valid`  out  1: `grad_out` and `mask_out` are valid.
- `out_ready`  in  1: consumer accepts the output.
- `grad_out`  out  VEC_SIZE*W: masked gradient, same packing.
- `mask_out`  out  VEC_SIZE: bit i = 1 when gradient element i was passed.

## Operation
- States: IDLE, BUSY, DONE.
- IDLE:
  - `in_ready` = 1 (decoded from state).
  - On `in_valid && in_ready`, register `act_in` and `grad_in`, clear the beat counter, go to BUSY.
- BUSY:
  - Each cycle, process elements k*LANES .. k*LANES+LANES-1, where k is the beat counter; write the results into the output registers; then k++.
  - After beat BEATS-1, go to DONE.
  - `in_valid` is ignored.
- DONE:
  - `out_valid` = 1.
  - On `out_ready`, go to IDLE.
  - While waiting, `grad_out` and `mask_out` are held bit-stable.
- Per-element rule:
  - pos = (sign == 0) && (exp/frac field != 0).
  - `grad_out[i]` = pos ? `grad_in[i]` : all-zero (+0).
  - `mask_out[i]` = pos.
- Classification cases:
  - −0 and +0 block.
  - Positive denormals pass.
  - +Inf passes.
  - NaN with sign 0 passes; NaN with sign 1 blocks.
  - No arithmetic is performed. Passed gradients are bit-exact copies, including NaN payloads.
- Beat counter width is clog2(BEATS), minimum 1 bit. It does not wrap inside a vector: the transition to DONE occurs at k == BEATS-1.
- Output registers are written only by BUSY beats. Stale elements are never visible, because `out_valid` is asserted only after every beat has written.
- `reset` takes priority over everything, including mid-BUSY and mid-DONE.
  - It aborts the vector and discards it.
  - State returns to IDLE, the counter clears, and the output registers clear.

## Timing
- Reset values:
  - state IDLE, so `in_ready` = 1;
  - `out_valid` = 0;
  - `grad_out` = 0;
  - `mask_out` = 0;
  - beat counter = 0.
- Acceptance happens at clock edge E0. BUSY occupies cycles 1..BEATS. `out_valid` rises in cycle BEATS+1.
  - Latency from acceptance to `out_valid` is BEATS+1 cycles.
- If `out_ready` is already high when `out_valid` rises, DONE lasts one cycle and `in_ready` is high the following cycle.
  - Maximum throughput is one vector per BEATS+2 cycles.
- `in_ready` is 0 in BUSY and DONE. Accept-while-draining is not supported.
- There is no combinational path from any input to any output, except that `in_ready`/`out_valid` are decoded from registered state only.

## Structure
- Shared header (the vector/float macro header):
  - element width macro W;
  - element select macro for index i;
  - positive-nonzero test macro (sign clear, magnitude nonzero).
- Sub-module `float_relu_grad`:
  - combinational, per element;
  - inputs: activation and gradient, both W bits;
  - outputs: masked gradient and pass bit.
  - Instantiated LANES times, selected by beat index.
- Top level holds the FSM, beat counter, input capture registers and output registers.

## Test plan
- fp32, VEC_SIZE=4, LANES=1, act = {1.0, −2.0, +0, −0} (0x3F800000, 0xC0000000, 0x00000000, 0x80000000), grad = {0x40400000 ×4}:
  - `grad_out` = {0x40400000, 0, 0, 0};
  - `mask_out` = 4'b0001;
  - `out_valid` in cycle 5 after acceptance.
- LANES=2, same vectors: identical result, `out_valid` in cycle 3.
- Edge classes, act = {0x00000001 denorm, 0x7F800000 +Inf, 0x7FC00001 +NaN, 0xFFC00000 −NaN}, grad = {0xDEADBEEF ×4}:
  - `mask_out` = 4'b0111;
  - element 3 = 0;
  - others = 0xDEADBEEF.
- Backpressure: hold `out_ready`=0 for 10 cycles in DONE:
  - outputs stay stable;
  - `in_ready` stays 0;
  - `in_valid` pulses are ignored.
  - Release `out_ready`: `in_ready` = 1 the next cycle.
- Reset asserted in BUSY beat 2 (VEC_SIZE=4, LANES=1):
  - next cycle state IDLE, `out_valid`=0, `grad_out`=0, `in_ready`=1;
  - a new vector is then processed correctly.
- Back-to-back streaming of 100 random vectors with random `in_valid`/`out_ready`: the scoreboard matches the per-element rule with no drops or duplicates.

Source files
------------

// File: rtl/vec_relu_grad_pkg.sv
// Shared types and sizing helpers for the vector ReLU backward pass.
// Imported by the top level and the per-element lane.
package vec_relu_grad_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Beat counter width: clog2(beats), never narrower than one bit.
    function automatic int beat_bits(input int beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

    // Float element width from its exponent and fraction fields.
    function automatic int elem_width(input int exp_width, input int frac_width);
        return 1 + exp_width + frac_width;
    endfunction

endpackage

// File: rtl/float_relu_grad.sv
// One ReLU-backward lane: passes the gradient bit-exactly when the forward
// activation is strictly positive (sign clear, exponent/fraction nonzero).
module float_relu_grad
    import vec_relu_grad_pkg::*;
#(
    parameter int EXP_WIDTH  = 8,
    parameter int FRAC_WIDTH = 23,
    localparam int W = elem_width(EXP_WIDTH, FRAC_WIDTH)
) (
    input  logic [W-1:0] act,
    input  logic [W-1:0] grad,
    output logic [W-1:0] grad_out,
    output logic         pass
);

    // NaN payloads and +Inf fall out of the rule naturally: only sign and
    // an all-zero magnitude block the gradient.
    assign pass     = ~act[W-1] & (|act[W-2:0]);
    assign grad_out = pass ? grad : '0;

endmodule

// File: rtl/vec_relu_grad.sv
// Vector ReLU backward pass: captures one activation/gradient vector, walks it
// LANES elements per beat, then holds the masked gradient until consumed.
module vec_relu_grad
    import vec_relu_grad_pkg::*;
#(
    parameter int EXP_WIDTH  = 8,
    parameter int FRAC_WIDTH = 23,
    parameter int VEC_SIZE   = 4,
    parameter int LANES      = 1,
    localparam int W = elem_width(EXP_WIDTH, FRAC_WIDTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [VEC_SIZE*W-1:0] act_in,
    input  logic [VEC_SIZE*W-1:0] grad_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [VEC_SIZE*W-1:0] grad_out,
    output logic [VEC_SIZE-1:0]   mask_out,
    output state_t                state_dbg
);

    // Handshakes: a transfer happens on a rising edge where valid && ready.
    // in_ready is high only in IDLE and out_valid only in DONE, both decoded
    // from registered state; once raised, out_valid and its data stay stable
    // until out_ready is seen. VEC_SIZE must be a multiple of LANES.
    localparam int BEATS = VEC_SIZE / LANES;
    localparam int CW    = beat_bits(BEATS);

    state_t                state;
    logic [CW-1:0]         beat;
    logic [VEC_SIZE*W-1:0] act_q;
    logic [VEC_SIZE*W-1:0] grad_q;
    logic [VEC_SIZE*W-1:0] grad_r;
    logic [VEC_SIZE-1:0]   mask_r;

    logic [W-1:0] lane_grad [LANES];
    logic         lane_pass [LANES];

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        float_relu_grad #(
            .EXP_WIDTH (EXP_WIDTH),
            .FRAC_WIDTH(FRAC_WIDTH)
        ) u_lane (
            .act     (act_q[(int'(beat) * LANES + l) * W +: W]),
            .grad    (grad_q[(int'(beat) * LANES + l) * W +: W]),
            .grad_out(lane_grad[l]),
            .pass    (lane_pass[l])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            beat   <= '0;
            act_q  <= '0;
            grad_q <= '0;
            grad_r <= '0;
            mask_r <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        act_q  <= act_in;
                        grad_q <= grad_in;
                        beat   <= '0;
                        state  <= BUSY;
                    end
                end
                BUSY: begin
                    for (int l = 0; l < LANES; l++) begin
                        grad_r[(int'(beat) * LANES + l) * W +: W] <= lane_grad[l];
                        mask_r[int'(beat) * LANES + l]            <= lane_pass[l];
                    end
                    // Counter stops at the last beat rather than wrapping.
                    if (beat == CW'(BEATS - 1)) begin
                        state <= DONE;
                    end else begin
                        beat <= beat + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign grad_out  = grad_r;
    assign mask_out  = mask_r;
    assign state_dbg = state;

endmodule
